exe_stage_reduced: RTL and testbench
====================================

// Module: exe_stage_reduced
// PURPOSE
//  Reduced single-issue integer execute stage of the in-order core (drac_pkg types): read-register stage -> exe -> writeback.
//  Executes ALU, MUL, DIV and BRANCH/JUMP ops on 64-bit operands; one scalar result port to WB.
//  Reports structural stalls to the control unit; reports resolved branches to fetch.
// PARAMETERS
//  XLEN  64  datapath width; fixed, matches drac_pkg bus64_t
// PORTS
//  clk_i                      in   1                      single clock, rising edge
//  rstn_i                     in   1                      reset, asynchronous, active-low
//  kill_i                     in   1                      flush: abort in-flight MUL/DIV, drop current instr
//  from_rr_i                  in   rr_exe_instr_t         instr (valid, unit, instr_type, use_imm, pc, imm), data_rs1/2, rdy1/2
//  exe_cu_o                   out  exe_cu_t               .stall = unit busy; .valid = result valid this cycle
//  exe_red_wb_o               out  exe_wb_scalar_instr_t  .valid, .result (rd data), .result_pc (jump target), .ex
//  pmu_struct_depend_stall_o  out  1                      equals exe_cu_o.stall
//  correct_branch_pred_o      out  1                      1 = resolved branch agrees with prediction
//  exe_if_branch_pred_o       out  exe_if_branch_pred_t   resolved pc/target/taken to fetch
// BEHAVIOUR
//  Reset: all outputs 0; MUL/DIV FSMs idle; held result regs 0.
//  Operand B = use_imm ? imm : data_rs2. All arithmetic mod 2^64.
//  ALU (UNIT_ALU): ADD a+b, SUB a-b, AND/OR/XOR, SLL/SRL/SRA (shamt b[5:0]), SLT/SLTU; *W variants use low 32, sign-extend.
//   Combinational: result on exe_red_wb_o in the same cycle as the input; stall=0.
//  BRANCH (UNIT_BRANCH), combinational, stall=0:
//   JAL: result=pc+4, result_pc=(pc+imm)&~1. JALR: result=pc+4, result_pc=(rs1+imm)&~1.
//   BEQ/BNE/BLT/BGE/BLTU/BGEU: taken -> result_pc=pc+imm, else pc+4; result=0.
//   correct_branch_pred_o=1 when taken/target equals from_rr_i prediction; exe_if_branch_pred_o driven only on valid branch.
//  MUL (UNIT_MUL): low 64 bits of rs1*rs2; 2-cycle pipelined.
//   Accept on valid & idle; stall=1 cycle 1; result registered and presented from cycle 2, stall=0.
//  DIV (UNIT_DIV): signed/unsigned DIV/REM, restoring radix-2, 1 bit/cycle.
//   Accept cycle + 64 iterations + 1 finish cycle; stall=1 throughout, drops the cycle result appears.
//   /0: quotient all-ones, remainder=rs1. Signed overflow (min/-1): quotient=min, rem=0.
//  Held result: MUL/DIV result stays on exe_red_wb_o.result after completion until the next accepted instr;
//   valid pulses one cycle at completion.
//  While stall=1 new from_rr_i instrs are ignored (upstream must hold them). valid deasserting mid-op does not abort.
//  kill_i: returns MUL/DIV to idle next edge, stall=0, no valid result; ALU/branch outputs masked to valid=0 same cycle.
//  Reset mid-operation: immediate abort, outputs to reset values.
//  Unknown unit/instr_type with valid: result 0, ex.valid=1 (illegal instruction).
// CONFIGURATION
//  EXE_RED_DIV_EN defined: divider instantiated as above.
//  Undefined: no divider; UNIT_DIV completes in 1 cycle, result=0, ex.valid=1 (illegal), stall never asserted for DIV.
// STRUCTURE
//  drac_pkg: rr_exe_instr_t, exe_wb_scalar_instr_t, exe_cu_t, exe_if_branch_pred_t, unit/instr_type enums, bus64_t.
//  One sub-module: exe_red_div_unit (iterative divider FSM IDLE->BUSY->DONE); ALU, branch, MUL inline.
// TESTING
//  ADD 100 random 64-bit pairs, use_imm=0 -> result=(rs1+rs2) mod 2^64 within 1 cycle.
//  SUB 100 random pairs -> result=rs1-rs2; e.g. 0x0-0x1 -> 0xFFFFFFFFFFFFFFFF.
//  MUL 100 random pairs, wait 2 cycles then until stall=0 -> result=low64(rs1*rs2).
//  DIV (macro defined) 0x10/0x3 -> wait until stall=0 -> result=0x5; x/0 -> 0xFFFFFFFFFFFFFFFF.
//  JAL pc=0x1000 imm=0x21 -> result=0x1004, result_pc=0x1020 half a cycle later.
//  JALR rs1=0x2001 imm=0x10 pc=0x40 -> result=0x44, result_pc=0x2010; kill_i during DIV -> stall=0 next cycle.

Source files
------------

// File: rtl/exe_stage_reduced_pkg.sv
// Shared types for the reduced execute stage: the drac_pkg subset it consumes.
// Instruction, writeback, control-unit and branch-resolution records plus opcode enums.
package exe_stage_reduced_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] bus64_t;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_DIV    = 3'd3
  } functional_unit_t;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } instr_type_t;

  typedef struct packed {
    logic   taken;
    bus64_t target;
  } branch_pred_t;

  typedef struct packed {
    logic             valid;
    functional_unit_t unit;
    instr_type_t      instr_type;
    logic             use_imm;
    bus64_t           pc;
    bus64_t           imm;
    branch_pred_t     bpred;
  } instr_t;

  typedef struct packed {
    instr_t instr;
    bus64_t data_rs1;
    bus64_t data_rs2;
    logic   rdy1;
    logic   rdy2;
  } rr_exe_instr_t;

  typedef struct packed {
    logic valid;
    logic stall;
  } exe_cu_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exception_t;

  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;

  typedef struct packed {
    logic       valid;
    bus64_t     result;
    bus64_t     result_pc;
    exception_t ex;
  } exe_wb_scalar_instr_t;

  typedef struct packed {
    bus64_t pc;
    bus64_t target;
    logic   taken;
  } exe_if_branch_pred_t;

  function automatic bus64_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/exe_stage_reduced_div.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle, for signed/unsigned DIV/REM.
// Only compiled when EXE_RED_DIV_EN is defined; otherwise the stage has no divider.
`ifdef EXE_RED_DIV_EN
// state  | meaning
// IDLE   | waiting for start_i; operands latched as magnitudes on start
// BUSY   | 64 shift/subtract iterations, cnt_q counts down to 0
// DONE   | sign fix-up of quotient/remainder, result registered, done pulse next cycle
module exe_red_div_unit
  import exe_stage_reduced_pkg::*;
(
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   kill_i,
  input  logic   start_i,
  input  logic   signed_i,
  input  logic   rem_i,
  input  bus64_t dividend_i,
  input  bus64_t divisor_i,
  output logic   busy_o,
  output logic   done_o,
  output bus64_t result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q;
  logic [6:0] cnt_q;
  bus64_t     rem_q, quo_q, divisor_q, result_q;
  logic       neg_q, neg_r, sel_rem, done_q;

  logic [64:0] rem_sh;
  bus64_t      rem_nxt, quo_nxt, final_res;

  function automatic bus64_t mag(input bus64_t v, input logic sgn);
    return (sgn & v[63]) ? -v : v;
  endfunction

  always_comb begin
    rem_sh = {rem_q, quo_q[63]};
    if (rem_sh >= {1'b0, divisor_q}) begin
      rem_nxt = rem_sh[63:0] - divisor_q;
      quo_nxt = {quo_q[62:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[63:0];
      quo_nxt = {quo_q[62:0], 1'b0};
    end
    if (sel_rem) final_res = neg_r ? -rem_q : rem_q;
    else         final_res = neg_q ? -quo_q : quo_q;
  end

  // Divide by zero falls out naturally: quotient all-ones, remainder = dividend (sign kept via neg_r).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sel_rem   <= 1'b0;
      done_q    <= 1'b0;
    end else if (kill_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            quo_q     <= mag(dividend_i, signed_i);
            divisor_q <= mag(divisor_i, signed_i);
            rem_q     <= '0;
            neg_q     <= signed_i & (dividend_i[63] ^ divisor_i[63]) & (divisor_i != '0);
            neg_r     <= signed_i & dividend_i[63];
            sel_rem   <= rem_i;
            cnt_q     <= 7'd63;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd0) state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= final_res;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`endif

// File: rtl/exe_stage_reduced.sv
// Reduced single-issue integer execute stage: inline ALU, branch and 2-cycle MUL, optional divider.
// Divider present only when EXE_RED_DIV_EN is defined; otherwise DIV ops raise illegal instruction.
module exe_stage_reduced
  import exe_stage_reduced_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 kill_i,
  input  rr_exe_instr_t        from_rr_i,
  output exe_cu_t              exe_cu_o,
  output exe_wb_scalar_instr_t exe_red_wb_o,
  output logic                 pmu_struct_depend_stall_o,
  output logic                 correct_branch_pred_o,
  output exe_if_branch_pred_t  exe_if_branch_pred_o
);

  bus64_t      op_a, op_b, rs2, pc, imm, pc_plus4;
  instr_type_t itype;
  logic        issue, accept;

  logic        mul_done_q;
  bus64_t      held_result_q, mul_prod;

  logic        div_busy, div_done, div_start;
  bus64_t      div_result;

  bus64_t      alu_res;
  logic        alu_legal;
  bus64_t      br_target, br_link;
  logic        br_legal, br_taken, br_cond;

  logic        comb_valid, comb_ill, start_mul, br_valid, out_valid, stall;
  bus64_t      comb_result, comb_pc;

  assign itype    = from_rr_i.instr.instr_type;
  assign op_a     = from_rr_i.data_rs1;
  assign rs2      = from_rr_i.data_rs2;
  assign op_b     = from_rr_i.instr.use_imm ? from_rr_i.instr.imm : rs2;
  assign pc       = from_rr_i.instr.pc;
  assign imm      = from_rr_i.instr.imm;
  assign pc_plus4 = pc + 64'd4;
  assign mul_prod = op_a * rs2;

  // A held instruction is not re-accepted in the cycle its MUL/DIV result is presented.
  assign issue  = from_rr_i.instr.valid & from_rr_i.rdy1 & from_rr_i.rdy2;
  assign accept = issue & ~kill_i & ~mul_done_q & ~div_busy & ~div_done;

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (itype)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[5:0];
      OP_SRL:  alu_res = op_a >> op_b[5:0];
      OP_SRA:  alu_res = bus64_t'($signed(op_a) >>> op_b[5:0]);
      OP_SLT:  alu_res = {63'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {63'd0, op_a < op_b};
      OP_ADDW: alu_res = sext32(op_a[31:0] + op_b[31:0]);
      OP_SUBW: alu_res = sext32(op_a[31:0] - op_b[31:0]);
      OP_SLLW: alu_res = sext32(op_a[31:0] << op_b[4:0]);
      OP_SRLW: alu_res = sext32(op_a[31:0] >> op_b[4:0]);
      OP_SRAW: alu_res = sext32($signed(op_a[31:0]) >>> op_b[4:0]);
      default: alu_legal = 1'b0;
    endcase
  end

  // Conditional branches compare the two registers; the immediate is always the offset.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    br_cond  = 1'b1;
    br_link  = '0;
    case (itype)
      OP_JAL:  begin br_taken = 1'b1; br_cond = 1'b0; br_link = pc_plus4; end
      OP_JALR: begin br_taken = 1'b1; br_cond = 1'b0; br_link = pc_plus4; end
      OP_BEQ:  br_taken = (op_a == rs2);
      OP_BNE:  br_taken = (op_a != rs2);
      OP_BLT:  br_taken = ($signed(op_a) <  $signed(rs2));
      OP_BGE:  br_taken = ($signed(op_a) >= $signed(rs2));
      OP_BLTU: br_taken = (op_a <  rs2);
      OP_BGEU: br_taken = (op_a >= rs2);
      default: begin br_legal = 1'b0; br_cond = 1'b0; end
    endcase
    if (itype == OP_JAL)       br_target = (pc + imm) & ~64'd1;
    else if (itype == OP_JALR) br_target = (op_a + imm) & ~64'd1;
    else if (br_cond & br_taken) br_target = pc + imm;
    else                         br_target = pc_plus4;
  end

  always_comb begin
    comb_valid  = 1'b0;
    comb_ill    = 1'b0;
    comb_result = '0;
    comb_pc     = '0;
    start_mul   = 1'b0;
    div_start   = 1'b0;
    br_valid    = 1'b0;
    if (accept) begin
      case (from_rr_i.instr.unit)
        UNIT_ALU: begin
          comb_valid = 1'b1;
          if (alu_legal) comb_result = alu_res;
          else           comb_ill    = 1'b1;
        end
        UNIT_BRANCH: begin
          comb_valid = 1'b1;
          if (br_legal) begin
            comb_result = br_link;
            comb_pc     = br_target;
            br_valid    = 1'b1;
          end else begin
            comb_ill = 1'b1;
          end
        end
        UNIT_MUL: begin
          if (itype == OP_MUL) start_mul = 1'b1;
          else begin comb_valid = 1'b1; comb_ill = 1'b1; end
        end
        UNIT_DIV: begin
`ifdef EXE_RED_DIV_EN
          if (itype inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) div_start = 1'b1;
          else begin comb_valid = 1'b1; comb_ill = 1'b1; end
`else
          comb_valid = 1'b1;
          comb_ill   = 1'b1;
`endif
        end
        default: begin
          comb_valid = 1'b1;
          comb_ill   = 1'b1;
        end
      endcase
    end
  end

`ifdef EXE_RED_DIV_EN
  exe_red_div_unit u_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .kill_i     (kill_i),
    .start_i    (div_start),
    .signed_i   ((itype == OP_DIV) || (itype == OP_REM)),
    .rem_i      ((itype == OP_REM) || (itype == OP_REMU)),
    .dividend_i (op_a),
    .divisor_i  (rs2),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .result_o   (div_result)
  );
`else
  assign div_busy   = 1'b0;
  assign div_done   = 1'b0;
  assign div_result = '0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mul_done_q    <= 1'b0;
      held_result_q <= '0;
    end else begin
      mul_done_q <= start_mul;
      if (start_mul)               held_result_q <= mul_prod;
      else if (comb_valid)         held_result_q <= comb_result;
      else if (div_done & ~kill_i) held_result_q <= div_result;
    end
  end

  assign out_valid = ~kill_i & (comb_valid | mul_done_q | div_done);
  assign stall     = ~kill_i & (start_mul | div_start | div_busy);

  always_comb begin
    exe_red_wb_o.valid     = out_valid;
    exe_red_wb_o.result    = comb_valid ? comb_result : (div_done ? div_result : held_result_q);
    exe_red_wb_o.result_pc = comb_pc;
    exe_red_wb_o.ex.valid  = comb_ill;
    exe_red_wb_o.ex.cause  = comb_ill ? CAUSE_ILLEGAL_INSTR : 4'd0;

    exe_cu_o.valid = out_valid;
    exe_cu_o.stall = stall;
    pmu_struct_depend_stall_o = stall;

    exe_if_branch_pred_o = '0;
    correct_branch_pred_o = 1'b0;
    if (br_valid) begin
      exe_if_branch_pred_o.pc     = pc;
      exe_if_branch_pred_o.target = br_target;
      exe_if_branch_pred_o.taken  = br_taken;
      correct_branch_pred_o = (br_taken == from_rr_i.instr.bpred.taken) &&
                              (!br_taken || (br_target == from_rr_i.instr.bpred.target));
    end
  end

endmodule

// File: tb/tb_exe_stage_reduced.sv
// Randomized self-checking bench for exe_stage_reduced against a behavioural reference model.
// DIV checks follow EXE_RED_DIV_EN: real division when defined, illegal-instruction otherwise.
module tb_exe_stage_reduced;
  import exe_stage_reduced_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic                 kill_i;
  rr_exe_instr_t        rr;
  exe_cu_t              cu;
  exe_wb_scalar_instr_t wb;
  logic                 pmu;
  logic                 corr;
  exe_if_branch_pred_t  bp;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  exe_stage_reduced dut (
    .clk_i                     (clk_i),
    .rstn_i                    (rstn_i),
    .kill_i                    (kill_i),
    .from_rr_i                 (rr),
    .exe_cu_o                  (cu),
    .exe_red_wb_o              (wb),
    .pmu_struct_depend_stall_o (pmu),
    .correct_branch_pred_o     (corr),
    .exe_if_branch_pred_o      (bp)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic issue(input functional_unit_t u, input instr_type_t t, input bit [63:0] a,
                       input bit [63:0] b, input bit [63:0] imm, input bit use_imm,
                       input bit [63:0] pc, input bit ptaken = 1'b0,
                       input bit [63:0] ptarget = 64'd0, input bit k = 1'b0);
    @(posedge clk_i); #1;
    rr = '0;
    rr.instr.valid        = 1'b1;
    rr.instr.unit         = u;
    rr.instr.instr_type   = t;
    rr.instr.use_imm      = use_imm;
    rr.instr.pc           = pc;
    rr.instr.imm          = imm;
    rr.instr.bpred.taken  = ptaken;
    rr.instr.bpred.target = ptarget;
    rr.data_rs1 = a;
    rr.data_rs2 = b;
    rr.rdy1 = 1'b1;
    rr.rdy2 = 1'b1;
    kill_i = k;
    @(negedge clk_i);
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    rr.instr.valid = 1'b0;
    kill_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Holds the current instruction (upstream behaviour under stall) until stall drops.
  task automatic wait_unstall(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      cycles++;
      if (!cu.stall) ok = 1'b1;
    end
  endtask

  function automatic bit [63:0] ref_alu(input instr_type_t t, input bit [63:0] a, input bit [63:0] b);
    longint sa, sb, r;
    int wa, wb32, w;
    sa = a; sb = b;
    wa = a[31:0]; wb32 = b[31:0];
    r = 0;
    case (t)
      OP_ADD:  r = sa + sb;
      OP_SUB:  r = sa - sb;
      OP_AND:  r = sa & sb;
      OP_OR:   r = sa | sb;
      OP_XOR:  r = sa ^ sb;
      OP_SLL:  r = a << b[5:0];
      OP_SRL:  r = a >> b[5:0];
      OP_SRA:  r = sa >>> b[5:0];
      OP_SLT:  r = (sa < sb) ? 1 : 0;
      OP_SLTU: r = (a < b) ? 1 : 0;
      OP_ADDW: begin w = wa + wb32; r = w; end
      OP_SUBW: begin w = wa - wb32; r = w; end
      OP_SLLW: begin w = wa << b[4:0]; r = w; end
      OP_SRLW: begin w = a[31:0] >> b[4:0]; r = w; end
      OP_SRAW: begin w = wa >>> b[4:0]; r = w; end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic bit ref_taken(input instr_type_t t, input bit [63:0] a, input bit [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (t)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit [63:0] ref_div(input instr_type_t t, input bit [63:0] a, input bit [63:0] b);
    longint sa, sb;
    bit [63:0] minv;
    sa = a; sb = b;
    minv = 64'h8000_0000_0000_0000;
    case (t)
      OP_DIVU: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (a == minv && sb == -1) return minv;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == minv && sb == -1) return 64'd0;
        return sa % sb;
      end
      default: return 64'd0;
    endcase
  endfunction

  instr_type_t alu_ops [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                                OP_SLT, OP_SLTU, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW};
  instr_type_t br_ops [6]   = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  instr_type_t div_ops [4]  = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  initial begin
    bit [63:0] a, b, imm, pc, exp, tgt, last_prod;
    bit tk, ptk, ok;
    int cyc;
    instr_type_t t;

    rstn_i = 1'b0;
    kill_i = 1'b0;
    rr = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", wb.valid, 0);
    chk("rst_result", wb.result, 0);
    chk("rst_stall", cu.stall, 0);
    chk("rst_pmu", pmu, 0);
    chk("rst_corr", corr, 0);
    chk("rst_bp_target", bp.target, 0);
    @(posedge clk_i); #1 rstn_i = 1'b1;

    for (int i = 0; i < 100; i++) begin
      a = rand64(); b = rand64();
      issue(UNIT_ALU, OP_ADD, a, b, 64'd0, 1'b0, 64'd0);
      chk("add_valid", wb.valid, 1);
      chk("add", wb.result, a + b);
      chk("add_stall", cu.stall, 0);
    end

    issue(UNIT_ALU, OP_SUB, 64'd0, 64'd1, 64'd0, 1'b0, 64'd0);
    chk("sub_0_1", wb.result, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 100; i++) begin
      a = rand64(); b = rand64();
      issue(UNIT_ALU, OP_SUB, a, b, 64'd0, 1'b0, 64'd0);
      chk("sub", wb.result, a - b);
    end

    a = rand64(); b = rand64(); imm = rand64();
    issue(UNIT_ALU, OP_ADD, a, b, imm, 1'b1, 64'd0);
    chk("add_imm", wb.result, a + imm);
    chk("alu_no_branch", corr, 0);
    chk("alu_bp_taken", bp.taken, 0);

    for (int i = 0; i < 120; i++) begin
      t = alu_ops[$urandom_range(14)];
      a = rand64();
      b = ($urandom_range(1) == 1) ? rand64() : 64'($urandom_range(70));
      issue(UNIT_ALU, t, a, b, 64'd0, 1'b0, 64'd0);
      chk($sformatf("alu_%s", t.name()), wb.result, ref_alu(t, a, b));
      chk("alu_ex", wb.ex.valid, 0);
    end
    issue(UNIT_ALU, OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0, 64'd0);
    chk("sra_63", wb.result, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(UNIT_ALU, OP_SLL, 64'd1, 64'd63, 64'd0, 1'b0, 64'd0);
    chk("sll_63", wb.result, 64'h8000_0000_0000_0000);
    issue(UNIT_ALU, OP_ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0);
    chk("addw_wrap", wb.result, 64'hFFFF_FFFF_8000_0000);

    issue(functional_unit_t'(3'd6), OP_ADD, 64'd5, 64'd6, 64'd0, 1'b0, 64'd0);
    chk("ill_unit_valid", wb.valid, 1);
    chk("ill_unit_ex", wb.ex.valid, 1);
    chk("ill_unit_result", wb.result, 0);
    issue(UNIT_MUL, OP_ADD, 64'd5, 64'd6, 64'd0, 1'b0, 64'd0);
    chk("ill_mul_ex", wb.ex.valid, 1);
    chk("ill_mul_stall", cu.stall, 0);

    issue(UNIT_ALU, OP_ADD, 64'd5, 64'd6, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    chk("kill_alu_valid", wb.valid, 0);
    idle();

    issue(UNIT_BRANCH, OP_JAL, 64'd0, 64'd0, 64'h21, 1'b0, 64'h1000, 1'b1, 64'h1020);
    chk("jal_result", wb.result, 64'h1004);
    chk("jal_result_pc", wb.result_pc, 64'h1020);
    chk("jal_taken", bp.taken, 1);
    chk("jal_corr", corr, 1);
    issue(UNIT_BRANCH, OP_JALR, 64'h2001, 64'd0, 64'h10, 1'b0, 64'h40, 1'b1, 64'h3000);
    chk("jalr_result", wb.result, 64'h44);
    chk("jalr_result_pc", wb.result_pc, 64'h2010);
    chk("jalr_corr", corr, 0);
    chk("jalr_bp_pc", bp.pc, 64'h40);

    for (int i = 0; i < 60; i++) begin
      t = br_ops[$urandom_range(5)];
      a = rand64();
      b = ($urandom_range(2) == 0) ? a : rand64();
      pc = rand64() & ~64'd3;
      imm = 64'($urandom_range(4095)) << 1;
      tk = ref_taken(t, a, b);
      exp = tk ? pc + imm : pc + 64'd4;
      ptk = $urandom_range(1);
      tgt = ptk ? (($urandom_range(1) == 1) ? pc + imm : pc + imm + 64'd8) : pc + 64'd4;
      issue(UNIT_BRANCH, t, a, b, imm, 1'b0, pc, ptk, tgt);
      chk($sformatf("br_pc_%s", t.name()), wb.result_pc, exp);
      chk("br_result", wb.result, 0);
      chk("br_taken", bp.taken, tk);
      chk("br_corr", corr, (ptk == tk) && (!tk || tgt == exp));
    end

    for (int i = 0; i < 100; i++) begin
      a = rand64(); b = rand64();
      issue(UNIT_MUL, OP_MUL, a, b, 64'd0, 1'b0, 64'd0);
      chk("mul_stall_c1", cu.stall, 1);
      chk("mul_valid_c1", wb.valid, 0);
      wait_unstall(cyc, ok);
      chk("mul_unstall", ok, 1);
      chk("mul_latency", cyc, 1);
      chk("mul_valid", wb.valid, 1);
      last_prod = a * b;
      chk("mul", wb.result, last_prod);
    end
    idle();
    chk("mul_held", wb.result, last_prod);
    chk("mul_held_valid", wb.valid, 0);

`ifdef EXE_RED_DIV_EN
    issue(UNIT_DIV, OP_DIVU, 64'h10, 64'h3, 64'd0, 1'b0, 64'd0);
    chk("div_stall_c1", cu.stall, 1);
    wait_unstall(cyc, ok);
    chk("div_unstall", ok, 1);
    chk("div_latency", cyc, 66);
    chk("div_valid", wb.valid, 1);
    chk("div_16_3", wb.result, 64'h5);
    idle();
    chk("div_held", wb.result, 64'h5);
    for (int i = 0; i < 16; i++) begin
      t = div_ops[i % 4];
      case (i / 4)
        0: begin a = rand64(); b = 64'd0; end
        1: begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: begin a = rand64(); b = 64'($urandom_range(1000)) + 64'd1; end
        default: begin a = rand64(); b = rand64() >> $urandom_range(60); end
      endcase
      issue(UNIT_DIV, t, a, b, 64'd0, 1'b0, 64'd0);
      wait_unstall(cyc, ok);
      chk("div_unstall", ok, 1);
      chk($sformatf("div_%s", t.name()), wb.result, ref_div(t, a, b));
    end
    issue(UNIT_DIV, OP_DIV, 64'd100, 64'd7, 64'd0, 1'b0, 64'd0);
    repeat (5) begin @(posedge clk_i); #1; @(negedge clk_i); end
    chk("div_mid_stall", cu.stall, 1);
    @(posedge clk_i); #1;
    kill_i = 1'b1;
    rr.instr.valid = 1'b0;
    @(negedge clk_i);
    idle();
    chk("kill_div_stall", cu.stall, 0);
    chk("kill_div_valid", wb.valid, 0);
    repeat (70) begin @(posedge clk_i); #1; @(negedge clk_i); chk("kill_div_no_result", wb.valid, 0); end
`else
    issue(UNIT_DIV, OP_DIVU, 64'h10, 64'h3, 64'd0, 1'b0, 64'd0);
    chk("nodiv_valid", wb.valid, 1);
    chk("nodiv_ex", wb.ex.valid, 1);
    chk("nodiv_result", wb.result, 0);
    chk("nodiv_stall", cu.stall, 0);
`endif

    a = rand64(); b = rand64();
    issue(UNIT_MUL, OP_MUL, a, b, 64'd0, 1'b0, 64'd0);
    @(posedge clk_i); #1;
    rr.instr.valid = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_valid", wb.valid, 0);
    chk("rst_mid_stall", cu.stall, 0);
    chk("rst_mid_result", wb.result, 0);
    @(negedge clk_i);
    @(posedge clk_i); #1 rstn_i = 1'b1;
    a = rand64(); b = rand64();
    issue(UNIT_ALU, OP_XOR, a, b, 64'd0, 1'b0, 64'd0);
    chk("post_rst_xor", wb.result, a ^ b);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
